// File: rtl/iir_biquad_sequencer.sv
// Time-multiplexed direct-form-I biquad sequencer driving an external
// sign-magnitude fixed-point multiplier, with one tap per cycle.
// Optional macro IIR_SAT_COUNT_EN adds a sticky 16-bit saturation event counter.
module iir_biquad_sequencer #(
    parameter int unsigned WIDTH = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sample,
    input  logic             coef_we,
    input  logic [2:0]       coef_addr,
    input  logic [WIDTH:0]   coef_data,
    output logic [WIDTH:0]   mul_a,
    output logic [WIDTH:0]   mul_b,
    input  logic [WIDTH:0]   mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sample,
    output logic             sat
`ifdef IIR_SAT_COUNT_EN
    ,
    output logic [15:0]      sat_count
`endif
);

    localparam int unsigned AW = WIDTH + 4;

    typedef enum logic [2:0] {
        StIdle, StMac0, StMac1, StMac2, StMac3, StMac4, StOut
    } state_e;

    state_e state;

    logic [WIDTH:0] b0, b1, b2, a1, a2;
    logic [WIDTH:0] x0, x1, x2, y1, y2;
    logic signed [AW-1:0] acc;

    logic                 fb_tap;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] sum;
    logic                 sum_neg;
    logic [AW-1:0]        sum_abs;
    logic                 sum_ovf;
    logic [WIDTH:0]       sum_sm;

    // No new sample while a clear is in progress.
    assign in_ready = (state == StIdle) && !clear;

    // Tap operand select; feedback taps get their product sign inverted.
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        fb_tap = 1'b0;
        case (state)
            StMac0:  begin mul_a = x0; mul_b = b0; end
            StMac1:  begin mul_a = x1; mul_b = b1; end
            StMac2:  begin mul_a = x2; mul_b = b2; end
            StMac3:  begin mul_a = y1; mul_b = a1; fb_tap = 1'b1; end
            StMac4:  begin mul_a = y2; mul_b = a2; fb_tap = 1'b1; end
            default: ;
        endcase
    end

    // Product to two's complement, running sum, and saturation to sign-magnitude.
    always_comb begin
        term = $signed({4'b0000, mul_result[WIDTH-1:0]});
        // Negating a zero magnitude yields zero, so -0 products add nothing.
        if (mul_result[WIDTH] ^ fb_tap) begin
            term = -term;
        end
        sum     = acc + term;
        sum_neg = sum[AW-1];
        sum_abs = sum_neg ? $unsigned(-sum) : $unsigned(sum);
        sum_ovf = |sum_abs[AW-1:WIDTH];
        if (sum_ovf) begin
            sum_sm = {sum_neg, {WIDTH{1'b1}}};
        end else begin
            sum_sm = {sum_neg, sum_abs[WIDTH-1:0]};
        end
    end

    // Sequencer FSM with coefficient, history and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            b0 <= '0; b1 <= '0; b2 <= '0; a1 <= '0; a2 <= '0;
            x0 <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            sat        <= 1'b0;
`ifdef IIR_SAT_COUNT_EN
            sat_count  <= '0;
`endif
        end else begin
            if (state == StIdle && coef_we) begin
                case (coef_addr)
                    3'd0:    b0 <= coef_data;
                    3'd1:    b1 <= coef_data;
                    3'd2:    b2 <= coef_data;
                    3'd3:    a1 <= coef_data;
                    3'd4:    a2 <= coef_data;
                    default: ;
                endcase
            end
            if (clear) begin
                state     <= StIdle;
                x0 <= '0; x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
                acc       <= '0;
                out_valid <= 1'b0;
                sat       <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (in_valid) begin
                            x0    <= in_sample;
                            acc   <= '0;
                            state <= StMac0;
                        end
                    end
                    StMac0: begin acc <= sum; state <= StMac1; end
                    StMac1: begin acc <= sum; state <= StMac2; end
                    StMac2: begin acc <= sum; state <= StMac3; end
                    StMac3: begin acc <= sum; state <= StMac4; end
                    StMac4: begin
                        acc        <= sum;
                        out_sample <= sum_sm;
                        sat        <= sum_ovf;
                        out_valid  <= 1'b1;
                        state      <= StOut;
                    end
                    StOut: begin
                        if (out_ready) begin
                            x2        <= x1;
                            x1        <= x0;
                            y2        <= y1;
                            y1        <= out_sample;
                            out_valid <= 1'b0;
                            state     <= StIdle;
`ifdef IIR_SAT_COUNT_EN
                            if (sat && sat_count != 16'hFFFF) begin
                                sat_count <= sat_count + 16'd1;
                            end
`endif
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Directed self-checking bench for iir_biquad_sequencer with a behavioural
// sign-magnitude Q15.16 multiplier model.
module tb_iir_biquad_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sample = '0;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [31:0] coef_data = '0;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sample;
    logic        sat;
`ifdef IIR_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    int checks = 0;
    int errors = 0;

    bit          got_ok;
    logic [31:0] got_s;
    logic        got_sat;

    always #5 clk = ~clk;

    iir_biquad_sequencer #(.WIDTH(31)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .sat        (sat)
`ifdef IIR_SAT_COUNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    // Multiplier model: magnitude product >> 16 fractional bits, clamped.
    logic [63:0] prod, prod_sh;
    logic [30:0] prod_mag;
    always_comb begin
        prod     = {33'b0, mul_a[30:0]} * {33'b0, mul_b[30:0]};
        prod_sh  = prod >> 16;
        prod_mag = (prod_sh > 64'h7FFF_FFFF) ? 31'h7FFF_FFFF : prod_sh[30:0];
        mul_result = {mul_a[31] ^ mul_b[31], prod_mag};
    end

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = addr; coef_data = data;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Assumes the DUT is idle.
    task automatic send(input logic [31:0] x);
        @(negedge clk);
        in_valid = 1'b1; in_sample = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output logic [31:0] s, output logic st);
        ok = 1'b0; s = '0; st = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1'b1; s = out_sample; st = sat;
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sample !== 32'h0 || sat !== 1'b0
            || mul_a !== 32'h0 || mul_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b s=%h sat=%b a=%h b=%h exp all zero",
                     out_valid, out_sample, sat, mul_a, mul_b);
        end
        do_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        // Coefficients reset to zero, so any input yields zero.
        send(32'h0001_0000);
        wait_out(got_ok, got_s, got_sat);
        checks++;
        if (!got_ok || got_s !== 32'h0 || got_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_coefs got ok=%0d s=%h sat=%b exp 00000000", got_ok, got_s, got_sat);
        end
    endtask

    task automatic test_pass_through();
        bit lat_ok;
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        @(negedge clk);
        in_valid = 1'b1; in_sample = 32'h0003_8000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (mul_a !== 32'h0003_8000 || mul_b !== 32'h0001_0000) begin
            errors++;
            $display("FAIL mac0_operands got a=%h b=%h exp 00038000 00010000", mul_a, mul_b);
        end
        lat_ok = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== (i == 5)) lat_ok = 1'b0;
        end
        checks++;
        if (!lat_ok) begin
            errors++;
            $display("FAIL latency got out_valid=%b after 5 edges exp exactly at edge 5", out_valid);
        end
        checks++;
        if (out_sample !== 32'h0003_8000 || sat !== 1'b0) begin
            errors++;
            $display("FAIL pass_sample got %h sat=%b exp 00038000 sat=0", out_sample, sat);
        end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pass_handshake got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_sign();
        logic [31:0] xs [2];
        logic [31:0] ys [2];
        xs[0] = 32'h0002_0000; ys[0] = 32'h0002_0000;
        xs[1] = 32'h8001_0000; ys[1] = 32'h0000_0000;
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd1, 32'h0000_8000);
        for (int i = 0; i < 2; i++) begin
            send(xs[i]);
            wait_out(got_ok, got_s, got_sat);
            checks++;
            if (!got_ok || got_s !== ys[i]) begin
                errors++;
                $display("FAIL sign_%0d got ok=%0d s=%h exp %h", i, got_ok, got_s, ys[i]);
            end
        end
    endtask

    task automatic test_feedback();
        logic [31:0] ys [4];
        ys[0] = 32'h0001_0000; ys[1] = 32'h0000_8000;
        ys[2] = 32'h0000_4000; ys[3] = 32'h0000_2000;
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd3, 32'h8000_8000);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 32'h0001_0000 : 32'h0);
            wait_out(got_ok, got_s, got_sat);
            checks++;
            if (!got_ok || got_s !== ys[i]) begin
                errors++;
                $display("FAIL feedback_%0d got ok=%0d s=%h exp %h", i, got_ok, got_s, ys[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] xs [4];
        logic [31:0] ys [4];
        logic        ss [4];
        xs[0] = 32'h7FFF_FFFF; ys[0] = 32'h7FFF_FFFF; ss[0] = 1'b0;
        xs[1] = 32'h7FFF_FFFF; ys[1] = 32'h7FFF_FFFF; ss[1] = 1'b1;
        xs[2] = 32'hFFFF_FFFF; ys[2] = 32'h0000_0000; ss[2] = 1'b0;
        xs[3] = 32'hFFFF_FFFF; ys[3] = 32'hFFFF_FFFF; ss[3] = 1'b1;
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd1, 32'h0001_0000);
        for (int i = 0; i < 4; i++) begin
            send(xs[i]);
            wait_out(got_ok, got_s, got_sat);
            checks++;
            if (!got_ok || got_s !== ys[i] || got_sat !== ss[i]) begin
                errors++;
                $display("FAIL sat_%0d got ok=%0d s=%h sat=%b exp %h sat=%b",
                         i, got_ok, got_s, got_sat, ys[i], ss[i]);
            end
        end
`ifdef IIR_SAT_COUNT_EN
        checks++;
        if (sat_count !== 16'd2) begin
            errors++;
            $display("FAIL sat_count got %0d exp 2", sat_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit seen;
        bit stable;
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd1, 32'h0000_8000);
        write_coef(3'd2, 32'h0000_4000);
        @(negedge clk);
        in_valid = 1'b1; in_sample = 32'h0002_0000; out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || out_sample !== 32'h0002_0000) begin
            errors++;
            $display("FAIL bp_first got seen=%0d s=%h exp 00020000", seen, out_sample);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sample !== 32'h0002_0000)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold got v=%b rdy=%b s=%h exp 1 0 00020000",
                     out_valid, in_ready, out_sample);
        end
        out_ready = 1'b1; in_sample = 32'h0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got out_valid=%b exp 0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        wait_out(got_ok, got_s, got_sat);
        // x1=2.0 via b1=0.5 gives 1.0; a double shift would add x2 via b2.
        checks++;
        if (!got_ok || got_s !== 32'h0001_0000) begin
            errors++;
            $display("FAIL bp_shift_once got ok=%0d s=%h exp 00010000", got_ok, got_s);
        end
    endtask

    task automatic test_clear();
        bit seen;
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        write_coef(3'd1, 32'h0001_0000);
        send(32'h0001_0000);
        wait_out(got_ok, got_s, got_sat);
        checks++;
        if (!got_ok || got_s !== 32'h0001_0000) begin
            errors++;
            $display("FAIL clear_prime got ok=%0d s=%h exp 00010000", got_ok, got_s);
        end
        @(negedge clk);
        in_valid = 1'b1; in_sample = 32'h0002_0000;
        @(posedge clk);
        @(negedge clk);              // MAC0
        in_valid = 1'b0;
        @(negedge clk);              // MAC1
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 32'h0003_0000;
        @(negedge clk);              // MAC2
        coef_we = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL clear_no_output got out_valid=1 exp 0");
        end
        clear = 1'b1; in_valid = 1'b1; in_sample = 32'h0005_0000;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_ready got %b exp 0", in_ready);
        end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        // History zeroed and dropped write: 1.0*1.0 + 1.0*0.
        send(32'h0001_0000);
        wait_out(got_ok, got_s, got_sat);
        checks++;
        if (!got_ok || got_s !== 32'h0001_0000) begin
            errors++;
            $display("FAIL clear_history got ok=%0d s=%h exp 00010000", got_ok, got_s);
        end
        // Write in the accept cycle takes effect: 2.0*1.0 + 1.0*1.0.
        @(negedge clk);
        in_valid = 1'b1; in_sample = 32'h0001_0000;
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 32'h0002_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        wait_out(got_ok, got_s, got_sat);
        checks++;
        if (!got_ok || got_s !== 32'h0003_0000) begin
            errors++;
            $display("FAIL same_cycle_write got ok=%0d s=%h exp 00030000", got_ok, got_s);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        write_coef(3'd0, 32'h0001_0000);
        send(32'h0001_0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b a=%h b=%h exp 0 0 0", out_valid, mul_a, mul_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_idle got seen=%0d rdy=%b exp 0 1", seen, in_ready);
        end
        send(32'h0001_0000);
        wait_out(got_ok, got_s, got_sat);
        checks++;
        if (!got_ok || got_s !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_coefs got ok=%0d s=%h exp 00000000", got_ok, got_s);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_sign();
        test_feedback();
        test_saturation();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
